shift_exec_stage: RTL and testbench

Pipelined execute-stage shift unit for the CPU datapath. It accepts MIPS shift instructions (sll, srl, sra, sllv, srlv, srav) from issue and decodes the funct field into shift amount, direction and arith/logical controls. It drives the team's 32-bit mux barrel shifter (shift_mux) combinationally and registers the result towards writeback. Valid/ready handshakes on both sides provide backpressure.

---
 rtl/shift_exec_stage.sv | 143 ++++++++++++++
 tb/tb_shift_exec_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage execute shift unit: S1 holds the decoded MIPS shift instruction,
// shift_mux shifts it combinationally, and S2 registers the result for writeback.

module shift_mux (
  input  logic [31:0] data_i,
  input  logic [4:0]  sa_i,
  input  logic        right_i,
  input  logic        arith_i,
  output logic [31:0] result_o
);
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic        fill;
  logic [31:0] stage [6];

  // Left shifts run through the same right-shifting ladder on bit-reversed data.
  assign fill     = right_i & arith_i & data_i[31];
  assign stage[0] = right_i ? data_i : rev32(data_i);

  for (genvar k = 0; k < 5; k++) begin : g_ladder
    localparam int SH = 1 << k;
    assign stage[k+1] = sa_i[k] ? {{SH{fill}}, stage[k][31:SH]} : stage[k];
  end

  assign result_o = right_i ? stage[5] : rev32(stage[5]);
endmodule

module shift_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_func,
  input  logic [4:0]       in_shamt,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [4:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_tag,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid_q, s2_valid_q;
  logic [31:0]      s1_data_q;
  logic [4:0]       s1_sa_q, s1_tag_q;
  logic             s1_right_q, s1_arith_q, s1_illegal_q;
  logic [31:0]      out_result_q, result_d, mux_result;
  logic [4:0]       out_tag_q;
  logic             out_zero_q, out_illegal_q;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [4:0]       dec_sa;
  logic             dec_right, dec_arith, dec_illegal;
  logic             s1_adv, s2_adv;
  logic             unused_rs;

  assign unused_rs = ^in_rs[31:5];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    dec_sa      = in_shamt;
    dec_right   = 1'b0;
    dec_arith   = 1'b0;
    dec_illegal = 1'b0;
    case (in_func)
      6'b000000: ;
      6'b000010: dec_right = 1'b1;
      6'b000011: begin dec_right = 1'b1; dec_arith = 1'b1; end
      6'b000100: dec_sa = in_rs[4:0];
      6'b000110: begin dec_sa = in_rs[4:0]; dec_right = 1'b1; end
      6'b000111: begin dec_sa = in_rs[4:0]; dec_right = 1'b1; dec_arith = 1'b1; end
      default:   dec_illegal = 1'b1;
    endcase
  end

  // in_ready deliberately follows out_ready combinationally so a full pipe still streams.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  shift_mux u_shift_mux (
    .data_i   (s1_data_q),
    .sa_i     (s1_sa_q),
    .right_i  (s1_right_q),
    .arith_i  (s1_arith_q),
    .result_o (mux_result)
  );

  assign result_d   = s1_illegal_q ? 32'd0 : mux_result;
  assign op_count_d = (s2_valid_q && out_ready) ? op_count_q + 1'b1 : op_count_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q  <= result_d;
          out_tag_q     <= s1_tag_q;
          out_zero_q    <= (result_d == 32'd0);
          out_illegal_q <= s1_illegal_q;
        end
      end
      op_count_q <= op_count_d;
    end
  end

  // NOTE: S1 payload is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data_q    <= in_rt;
      s1_sa_q      <= dec_sa;
      s1_right_q   <= dec_right;
      s1_arith_q   <= dec_arith;
      s1_tag_q     <= in_tag;
      s1_illegal_q <= dec_illegal;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign op_count    = op_count_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: accepted ops are modelled into a scoreboard queue
// and compared in order as results complete; scenario tasks add timing checks.

module tb_shift_exec_stage;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [5:0]       in_func;
  logic [4:0]       in_shamt;
  logic [31:0]      in_rs, in_rt;
  logic [4:0]       in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_tag;
  logic             out_zero, out_illegal;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        zero;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  shift_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] tag);
    exp_t e;
    e.illegal = 1'b0;
    e.tag     = tag;
    case (f)
      6'b000000: e.result = rt << sh;
      6'b000010: e.result = rt >> sh;
      6'b000011: e.result = $signed(rt) >>> sh;
      6'b000100: e.result = rt << rs[4:0];
      6'b000110: e.result = rt >> rs[4:0];
      6'b000111: e.result = $signed(rt) >>> rs[4:0];
      default: begin e.result = 32'd0; e.illegal = 1'b1; end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Inputs change only #1 after posedge, so the negedge sees what the next edge transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        exp_t got, exp;
        got = '{out_result, out_tag, out_zero, out_illegal};
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got result=%h tag=%0d with nothing expected", out_result, out_tag);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL sb_result: got result=%h tag=%0d zero=%b ill=%b, want result=%h tag=%0d zero=%b ill=%b",
                     got.result, got.tag, got.zero, got.illegal, exp.result, exp.tag, exp.zero, exp.illegal);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_func, in_shamt, in_rs, in_rt, in_tag));
    end
  end

  task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] tag);
    bit ok = 0;
    in_valid = 1'b1; in_func = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_tag = tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_accept: in_ready=%b, want 1 within 20 cycles", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin done = 1; break; end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL drain: %0d results outstanding, want 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, op_count, out_result, out_tag, out_zero, out_illegal}
        !== {1'b0, 1'b1, {CNT_W{1'b0}}, 32'd0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b cnt=%0d res=%h tag=%0d z=%b ill=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, op_count, out_result, out_tag, out_zero, out_illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sll_latency();
    send(6'b000000, 5'd4, 32'd0, 32'h0000_00F1, 5'd3);
    idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_lat1: out_valid=%b, want 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_result, out_tag, out_zero} !== {1'b1, 32'h0000_0F10, 5'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL sll_lat2: valid=%b res=%h tag=%0d z=%b, want 1 00000f10 3 0", out_valid, out_result, out_tag, out_zero);
    end
    @(negedge clk);
    n_checks++;
    if (op_count !== 16'd1) begin n_fail++; $display("FAIL sll_count: op_count=%0d, want 1", op_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_right_shifts();
    send(6'b000011, 5'd8,  32'd0, 32'h8000_1234, 5'd4);
    send(6'b000010, 5'd8,  32'd0, 32'h8000_1234, 5'd5);
    send(6'b000011, 5'd31, 32'd0, 32'h8000_0000, 5'd6);
    idle();
    wait_drain();
  endtask

  task automatic test_var_shifts();
    send(6'b000111, 5'd9, 32'hFFFF_FFE4, 32'hF000_0000, 5'd7);
    send(6'b000100, 5'd9, 32'h0000_0020, 32'h1234_5678, 5'd8);
    send(6'b000100, 5'd0, 32'h0000_0001, 32'h8000_0000, 5'd9);
    send(6'b000110, 5'd0, 32'h0000_0010, 32'hABCD_0000, 5'd10);
    idle();
    wait_drain();
  endtask

  task automatic test_illegal();
    send(6'b100000, 5'd3, 32'd0, 32'hFFFF_FFFF, 5'd11);
    send(6'b000000, 5'd1, 32'd0, 32'h0000_0001, 5'd12);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] base;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    bit          have_held = 0;
    int idx = 0, accepts = 0, run = 0;
    base = op_count;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4); in_func = 6'b000000; in_shamt = 5'(idx + 1);
      in_rs = 32'd0; in_rt = 32'h0000_0101 * (idx + 1); in_tag = 5'(16 + idx);
      @(negedge clk);
      if (out_valid) begin
        if (have_held) begin
          n_checks++;
          if ({out_result, out_tag} !== {held_res, held_tag}) begin
            n_fail++;
            $display("FAIL stall_stable: res=%h tag=%0d, want %h %0d", out_result, out_tag, held_res, held_tag);
          end
        end else begin
          held_res = out_result; held_tag = out_tag; have_held = 1;
        end
      end
      if (in_valid && in_ready) begin accepts++; idx++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (accepts !== 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accepts: accepts=%0d in_ready=%b, want 2 0", accepts, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4); in_func = 6'b000000; in_shamt = 5'(idx + 1);
      in_rs = 32'd0; in_rt = 32'h0000_0101 * (idx + 1); in_tag = 5'(16 + idx);
      @(negedge clk);
      if (out_valid && c == run) run++;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (run !== 4) begin n_fail++; $display("FAIL release_stream: consecutive outputs=%0d, want 4", run); end
    n_checks++;
    if (op_count !== base + 16'd4) begin
      n_fail++; $display("FAIL release_count: op_count=%0d, want %0d", op_count, base + 16'd4);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b0;
    send(6'b000000, 5'd1, 32'd0, 32'h1, 5'd20);
    send(6'b000000, 5'd2, 32'd0, 32'h1, 5'd21);
    idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    send(6'b000000, 5'd3, 32'd0, 32'h1, 5'd22);
    rst = 1'b0; idle();
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: out_valid=%b op_count=%0d in_ready=%b, want 0 0 1", out_valid, op_count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin n_fail++; $display("FAIL stale_result: saw %0d outputs after reset, want 0", stale); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_func = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sll_latency();
    test_right_shifts();
    test_var_shifts();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: %0d queued, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
